// File: rtl/palm_ctrl_pkg.sv
// palm_ctrl_pkg
// Shared types and constants for the palm-identification frame sequencer:
// FSM state encoding, coordinate width, default frame geometry/timeout and
// the bounding-box result record.
package palm_ctrl_pkg;

  localparam int unsigned COORD_W     = 8;
  localparam int unsigned DEF_IMG_W   = 64;
  localparam int unsigned DEF_IMG_H   = 48;
  localparam int unsigned DEF_TIMEOUT = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_STREAM,
    ST_WAIT_DP,
    ST_HOLD
  } state_e;

  typedef struct packed {
    logic [COORD_W-1:0] start_r;
    logic [COORD_W-1:0] start_c;
    logic [COORD_W-1:0] end_r;
    logic [COORD_W-1:0] end_c;
    logic [COORD_W-1:0] height;
    logic [COORD_W-1:0] width;
  } bbox_t;

endpackage

// File: rtl/raster_counter.sv
// raster_counter
// Row/column tracker for a raster-order pixel stream.
//   clk, rst      : clock, asynchronous active-low reset
//   clear         : force position back to (0,0)
//   advance       : one pixel accepted this cycle
//   row, col      : position of the next pixel to accept
//   last_pixel    : current position is the final pixel of the frame
module raster_counter
  import palm_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               advance,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col,
  output logic               last_pixel
);

  logic [COORD_W-1:0] row_q, row_d;
  logic [COORD_W-1:0] col_q, col_d;
  logic               col_last;

  assign col_last   = (col_q == COORD_W'(IMG_W - 1));
  assign last_pixel = col_last && (row_q == COORD_W'(IMG_H - 1));

  always_comb begin
    row_d = row_q;
    col_d = col_q;
    if (clear) begin
      row_d = '0;
      col_d = '0;
    end else if (advance) begin
      if (last_pixel) begin
        row_d = '0;
        col_d = '0;
      end else if (col_last) begin
        row_d = row_q + 1'b1;
        col_d = '0;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      row_q <= '0;
      col_q <= '0;
    end else begin
      row_q <= row_d;
      col_q <= col_d;
    end
  end

  assign row = row_q;
  assign col = col_q;

endmodule

// File: rtl/palm_frame_sequencer.sv
// palm_frame_sequencer
// Sequences the palm-identification datapath over one binary frame:
// arm on frame_start, pulse dp_clear, stream pixels with raster tracking,
// wait (with timeout) for the datapath bounding box, then hold the result
// on a valid/ready handshake.
//   clk, rst                     : clock, asynchronous active-low reset
//   frame_start/test_mode/test_height : arm request and per-frame config
//   pix_in/pix_valid/pix_ready   : incoming object-image pixel stream
//   dp_*  (out)                  : clear, pixel, frame-end and config to datapath
//   dp_done, dp_* (in)           : datapath bounding-box result
//   res_*, res_valid/res_ready   : captured result to downstream
//   busy, row, col               : status and next raster position
module palm_frame_sequencer
  import palm_ctrl_pkg::*;
#(
  parameter int unsigned IMG_W   = DEF_IMG_W,
  parameter int unsigned IMG_H   = DEF_IMG_H,
  parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               frame_start,
  input  logic               test_mode,
  input  logic [7:0]         test_height,
  input  logic               pix_in,
  input  logic               pix_valid,
  output logic               pix_ready,
  output logic               dp_clear,
  output logic               dp_object_image,
  output logic               dp_pixel_en,
  output logic               dp_frame_end,
  output logic               dp_testing_switch,
  output logic [7:0]         dp_palm_height_test,
  input  logic               dp_done,
  input  logic [COORD_W-1:0] dp_start_r,
  input  logic [COORD_W-1:0] dp_start_c,
  input  logic [COORD_W-1:0] dp_end_r,
  input  logic [COORD_W-1:0] dp_end_c,
  input  logic [COORD_W-1:0] dp_height,
  input  logic [COORD_W-1:0] dp_width,
  output logic [COORD_W-1:0] res_start_r,
  output logic [COORD_W-1:0] res_start_c,
  output logic [COORD_W-1:0] res_end_r,
  output logic [COORD_W-1:0] res_end_c,
  output logic [COORD_W-1:0] res_height,
  output logic [COORD_W-1:0] res_width,
  output logic               res_valid,
  output logic               res_timeout,
  input  logic               res_ready,
  output logic               busy,
  output logic [COORD_W-1:0] row,
  output logic [COORD_W-1:0] col
);

  state_e             state_q, state_d;
  logic               mode_q, mode_d;
  logic [7:0]         height_q, height_d;
  logic [COORD_W-1:0] timer_q, timer_d;
  bbox_t              res_q, res_d;
  logic               res_valid_q, res_valid_d;
  logic               res_timeout_q, res_timeout_d;
  logic               pix_en_q, pix_en_d;
  logic               pix_img_q, pix_img_d;
  logic               frame_end_q, frame_end_d;

  logic               rc_clear;
  logic               accept;
  logic               last_pixel;

  assign pix_ready = (state_q == ST_STREAM);
  assign dp_clear  = (state_q == ST_CLEAR);
  assign busy      = (state_q != ST_IDLE);
  assign accept    = pix_valid && pix_ready;

  raster_counter #(
    .IMG_W(IMG_W),
    .IMG_H(IMG_H)
  ) u_raster (
    .clk       (clk),
    .rst       (rst),
    .clear     (rc_clear),
    .advance   (accept),
    .row       (row),
    .col       (col),
    .last_pixel(last_pixel)
  );

  always_comb begin
    state_d       = state_q;
    mode_d        = mode_q;
    height_d      = height_q;
    timer_d       = timer_q;
    res_d         = res_q;
    res_valid_d   = res_valid_q;
    res_timeout_d = res_timeout_q;
    rc_clear      = 1'b0;
    pix_en_d      = accept;
    pix_img_d     = accept && pix_in;
    frame_end_d   = accept && last_pixel;

    case (state_q)
      ST_IDLE: begin
        if (frame_start) begin
          mode_d   = test_mode;
          height_d = test_height;
          rc_clear = 1'b1;
          state_d  = ST_CLEAR;
        end
      end
      ST_CLEAR: state_d = ST_STREAM;
      ST_STREAM: begin
        if (accept && last_pixel) begin
          timer_d = '0;
          state_d = ST_WAIT_DP;
        end
      end
      ST_WAIT_DP: begin
        timer_d = timer_q + 1'b1;
        // dp_done is checked first so it wins over a coincident timeout.
        if (dp_done) begin
          res_d         = '{dp_start_r, dp_start_c, dp_end_r, dp_end_c, dp_height, dp_width};
          res_timeout_d = 1'b0;
          res_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end else if (timer_q == COORD_W'(TIMEOUT - 1)) begin
          res_d         = '0;
          res_timeout_d = 1'b1;
          res_valid_d   = 1'b1;
          state_d       = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (res_ready) begin
          res_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= ST_IDLE;
      mode_q        <= 1'b0;
      height_q      <= '0;
      timer_q       <= '0;
      res_q         <= '0;
      res_valid_q   <= 1'b0;
      res_timeout_q <= 1'b0;
      pix_en_q      <= 1'b0;
      pix_img_q     <= 1'b0;
      frame_end_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      mode_q        <= mode_d;
      height_q      <= height_d;
      timer_q       <= timer_d;
      res_q         <= res_d;
      res_valid_q   <= res_valid_d;
      res_timeout_q <= res_timeout_d;
      pix_en_q      <= pix_en_d;
      pix_img_q     <= pix_img_d;
      frame_end_q   <= frame_end_d;
    end
  end

  assign dp_testing_switch   = mode_q;
  assign dp_palm_height_test = height_q;
  assign dp_pixel_en         = pix_en_q;
  assign dp_object_image     = pix_img_q;
  assign dp_frame_end        = frame_end_q;
  assign res_start_r         = res_q.start_r;
  assign res_start_c         = res_q.start_c;
  assign res_end_r           = res_q.end_r;
  assign res_end_c           = res_q.end_c;
  assign res_height          = res_q.height;
  assign res_width           = res_q.width;
  assign res_valid           = res_valid_q;
  assign res_timeout         = res_timeout_q;

endmodule

// File: doc/palm_frame_sequencer.md
# palm_frame_sequencer

Controller that sequences the palm-identification datapath over one binary object-image frame. It arms on a frame request and clears the datapath. It then streams pixels in raster order with row/column tracking, waits for the datapath's bounding-box result, applies a timeout, and hands the result downstream on a valid/ready handshake. It sits between the object-segmentation pixel stream and the palm-identification datapath.

## Interface
- IMG_W, 64: pixels per row (2..255)
- IMG_H, 48: rows per frame (2..255)
- TIMEOUT, 255: max cycles in WAIT_DP before forced completion (1..255)

- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- frame_start  in  1  arm request, sampled only in IDLE
- test_mode  in  1  latched at arm; drives dp_testing_switch for the whole frame
- test_height  in  8  latched at arm; drives dp_palm_height_test
- pix_in  in  1  object-image pixel
- pix_valid  in  1  pixel present
- pix_ready  out  1  sequencer accepts pixel
- dp_clear  out  1  one-cycle datapath clear pulse
- dp_object_image  out  1  registered pixel to datapath
- dp_pixel_en  out  1  dp_object_image is valid this cycle
- dp_frame_end  out  1  high with the last pixel's dp_pixel_en
- dp_testing_switch  out  1  latched test_mode
- dp_palm_height_test  out  8  latched test_height
- dp_done  in  1  datapath result ready
- dp_start_r, dp_start_c, dp_end_r, dp_end_c, dp_height, dp_width  in  8 each  datapath result
- res_start_r, res_start_c, res_end_r, res_end_c, res_height, res_width  out  8 each  captured result
- res_valid  out  1  result available
- res_timeout  out  1  result forced by timeout (qualified by res_valid)
- res_ready  in  1  downstream accepts result
- busy  out  1  state != IDLE
- row, col  out  8 each  raster position of the next pixel to accept

## Operation
- States: IDLE, CLEAR, STREAM, WAIT_DP, HOLD.
- IDLE: frame_start=1 latches test_mode/test_height, zeroes row/col → CLEAR.
- CLEAR: dp_clear=1 for exactly this cycle → STREAM.
- STREAM: pix_ready=1 (combinational, state==STREAM only). On pix_valid&pix_ready: dp_object_image<=pix_in, dp_pixel_en<=1 next cycle; col+1, wrap to 0 at IMG_W-1 with row+1.
- On the pixel at row=IMG_H-1 and col=IMG_W-1: dp_frame_end<=1 alongside its dp_pixel_en; row/col → 0; → WAIT_DP, timer cleared.
- WAIT_DP: timer increments each cycle. On dp_done=1, capture the six dp_* fields into res_*, res_timeout<=0, res_valid<=1 → HOLD.
- Timeout: if dp_done is still 0 when timer reaches TIMEOUT-1, res_* <= 0, res_timeout<=1, res_valid<=1 → HOLD. If dp_done and the timeout cycle coincide, dp_done wins.
- HOLD: res_* stable while res_valid=1. On res_ready=1, res_valid<=0 next edge → IDLE.
- Ignored inputs: frame_start outside IDLE; dp_done outside WAIT_DP; pix_valid outside STREAM.
- Reset (any time, including mid-frame): all outputs 0, row=col=0, timer=0, latched config 0, state IDLE.

## Timing
- Reset values: every output 0; pix_ready=0.
- Arm to first pix_ready: frame_start at edge N → dp_clear high cycle N+1 → pix_ready high from N+2.
- Pixel latency: accept at edge K → dp_pixel_en/dp_object_image at K+1. A gapless frame yields IMG_W*IMG_H consecutive dp_pixel_en cycles.
- pix_ready is low in the cycle after the last pixel is accepted.
- dp_done sampled at edge D → res_valid high from D+1.
- Timeout: res_valid rises TIMEOUT cycles after entering WAIT_DP.
- res_valid&res_ready at edge R → res_valid low and busy low after R. frame_start at R+1 is accepted.
- Back-to-back frames: minimum 2 idle-side cycles (IDLE, CLEAR) between a frame's last pixel and the next frame's first pixel, plus the result time.

## Structure
- Package palm_ctrl_pkg: state enum encoding, COORD_W=8, default IMG_W/IMG_H/TIMEOUT constants.
- Sub-module raster_counter: row/col registers, advance enable, clear input, wrap logic, and last_pixel flag. It is parameterised by IMG_W/IMG_H.
- Top contains the FSM, config latches, timer, result capture, and pixel output register.

## Test plan
Use IMG_W=4, IMG_H=3, TIMEOUT=10.
- Reset and arm: after reset, outputs are 0. frame_start pulse → dp_clear for 1 cycle, pix_ready from the following cycle, busy=1.
- Gapless frame: 12 pixels of pattern 0,0,1,1 repeating → 12 consecutive dp_pixel_en cycles with the matching dp_object_image. dp_frame_end coincides only with the 12th. row/col sequence (0,0)…(2,3)→(0,0).
- Throttled stream with random pix_valid gaps → same 12 dp_pixel_en. row/col advance only on accept.
- Result capture: dp_done 3 cycles after frame end with start_r=1, start_c=2, end_r=2, end_c=3, height=2, width=2 → res_* equal next cycle, res_timeout=0. res_ready held low 5 cycles → res_* stable. res_ready=1 → IDLE.
- Timeout: no dp_done → res_valid 10 cycles after WAIT_DP entry with res_timeout=1 and res_* all 0. dp_done on the 10th cycle → normal capture instead.
- Reset mid-frame: rst low after 5 pixels → all outputs 0 immediately. Re-arm → row/col start at (0,0). frame_start during STREAM/HOLD has no effect. test_height=8'd37 latched → dp_palm_height_test=37 for the frame, unaffected by later changes.
